// File: rtl/dot_product_sequencer.sv
// Sequencer in front of the FP32 MAC: streams operand pairs, drains, captures and returns the sum.
// Optional build macro DOT_RELU_EN clamps negative results (including -0.0) to +0.0.
module dot_product_sequencer #(
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [LEN_WIDTH-1:0]  Length,
  output logic                  Busy,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [DATA_WIDTH-1:0] In_A,
  input  logic [DATA_WIDTH-1:0] In_B,
  output logic                  Mac_Enable,
  output logic [DATA_WIDTH-1:0] Mac_In1,
  output logic [DATA_WIDTH-1:0] Mac_In2,
  input  logic [DATA_WIDTH-1:0] Mac_Out,
  output logic                  Res_Valid,
  input  logic                  Res_Ready,
  output logic [DATA_WIDTH-1:0] Res_Data
);

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDrain,
    StCapture,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  mac_en_q, mac_en_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d;
  logic [DATA_WIDTH-1:0] in2_q, in2_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                  in_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mac_en_q    <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mac_en_q    <= mac_en_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  // MAC inputs default to zero so bubbles and the drain cycle add +0.0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mac_en_d    = 1'b0;
    in1_d       = '0;
    in2_d       = '0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    in_ready    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (Length != '0) begin
            cnt_d   = Length;
            state_d = StAccum;
          end else begin
            res_data_d  = '0;
            res_valid_d = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StAccum: begin
        in_ready = 1'b1;
        mac_en_d = 1'b1;
        if (In_Valid) begin
          in1_d = In_A;
          in2_d = In_B;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_WIDTH'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Keep the MAC enabled one more edge so it folds in the last pair.
        mac_en_d = 1'b1;
        state_d  = StCapture;
      end
      StCapture: begin
`ifdef DOT_RELU_EN
        res_data_d = Mac_Out[DATA_WIDTH-1] ? '0 : Mac_Out;
`else
        res_data_d = Mac_Out;
`endif
        res_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (Res_Ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign Busy       = (state_q != StIdle);
  assign In_Ready   = in_ready;
  assign Mac_Enable = mac_en_q;
  assign Mac_In1    = in1_q;
  assign Mac_In2    = in2_q;
  assign Res_Valid  = res_valid_q;
  assign Res_Data   = res_data_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a behavioural FP32 MAC built on reals.
module tb_dot_product_sequencer;

  localparam int unsigned LenW = 4;

  logic            Clk;
  logic            Rst;
  logic            Start;
  logic [LenW-1:0] Length;
  logic            Busy;
  logic            In_Valid;
  logic            In_Ready;
  logic [31:0]     In_A;
  logic [31:0]     In_B;
  logic            Mac_Enable;
  logic [31:0]     Mac_In1;
  logic [31:0]     Mac_In2;
  logic [31:0]     Mac_Out;
  logic            Res_Valid;
  logic            Res_Ready;
  logic [31:0]     Res_Data;

  int checks = 0;
  int errors = 0;

  dot_product_sequencer #(
    .LEN_WIDTH (LenW),
    .DATA_WIDTH(32)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .Length    (Length),
    .Busy      (Busy),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_A      (In_A),
    .In_B      (In_B),
    .Mac_Enable(Mac_Enable),
    .Mac_In1   (Mac_In1),
    .Mac_In2   (Mac_In2),
    .Mac_Out   (Mac_Out),
    .Res_Valid (Res_Valid),
    .Res_Ready (Res_Ready),
    .Res_Data  (Res_Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // MAC: accumulates In1*In2 each enabled edge, clears while disabled, Out is the register.
  real acc = 0.0;
  always @(posedge Clk) begin
    if (!Mac_Enable) acc <= 0.0;
    else             acc <= acc + f2r(Mac_In1) * f2r(Mac_In2);
  end
  always_comb Mac_Out = r2f(acc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic start_vec(input logic [LenW-1:0] len);
    Start  = 1'b1;
    Length = len;
    step();
    Start  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b);
    In_Valid = 1'b1;
    In_A     = a;
    In_B     = b;
    check("in_ready_beat", In_Ready, 1);
    step();
    In_Valid = 1'b0;
    In_A     = '0;
    In_B     = '0;
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Length = '0; In_Valid = 1'b0;
    In_A = '0; In_B = '0; Res_Ready = 1'b0;
    step(2);
    Rst = 1'b0;
    check("rst_busy", Busy, 0);
    check("rst_in_ready", In_Ready, 0);
    check("rst_mac_en", Mac_Enable, 0);
    check("rst_res_valid", Res_Valid, 0);
    check("rst_res_data", Res_Data, 0);
    check("rst_mac_in1", Mac_In1, 0);

    // {1,2,3}.{4,5,6} = 32.0, no bubbles
    start_vec(3);
    check("t1_busy", Busy, 1);
    check("t1_mac_en_first", Mac_Enable, 0);
    beat(32'h3F800000, 32'h40800000);
    beat(32'h40000000, 32'h40A00000);
    beat(32'h40400000, 32'h40C00000);
    check("t1_drain_in_ready", In_Ready, 0);
    check("t1_drain_mac_in1", Mac_In1, 32'h40400000);
    check("t1_drain_mac_en", Mac_Enable, 1);
    check("t1_drain_valid", Res_Valid, 0);
    step();
    check("t1_capture_valid", Res_Valid, 0);
    step();
    check("t1_valid_k3", Res_Valid, 1);
    check("t1_data", Res_Data, 32'h42000000);

    // Backpressure with an ignored Start while Busy
    for (int i = 0; i < 5; i++) begin
      Start  = (i == 1);
      Length = 4'd1;
      step();
      check("bp_valid", Res_Valid, 1);
      check("bp_data", Res_Data, 32'h42000000);
      check("bp_in_ready", In_Ready, 0);
      check("bp_mac_en", Mac_Enable, 0);
    end
    Start = 1'b0;
    Res_Ready = 1'b1;
    step();
    check("bp_done_valid", Res_Valid, 0);
    check("bp_done_busy", Busy, 0);

    // Same vector with 2-cycle bubbles; Res_Ready already high
    start_vec(3);
    beat(32'h3F800000, 32'h40800000);
    step(2);
    check("t2_bubble_mac_en", Mac_Enable, 1);
    check("t2_bubble_in1", Mac_In1, 0);
    check("t2_bubble_in_ready", In_Ready, 1);
    beat(32'h40000000, 32'h40A00000);
    step(2);
    check("t2_bubble_mac_en2", Mac_Enable, 1);
    beat(32'h40400000, 32'h40C00000);
    step(2);
    check("t2_valid", Res_Valid, 1);
    check("t2_data", Res_Data, 32'h42000000);
    step();
    check("t2_handshake_first", Res_Valid, 0);
    check("t2_idle", Busy, 0);

    // 1.0 * -2.0
    start_vec(1);
    beat(32'h3F800000, 32'hC0000000);
    step(2);
    check("t3_valid", Res_Valid, 1);
`ifdef DOT_RELU_EN
    check("t3_data", Res_Data, 32'h00000000);
`else
    check("t3_data", Res_Data, 32'hC0000000);
`endif
    step();

    // Zero length
    Res_Ready = 1'b0;
    In_Valid  = 1'b1;
    In_A      = 32'h3F800000;
    In_B      = 32'h3F800000;
    start_vec(0);
    check("t4_valid", Res_Valid, 1);
    check("t4_data", Res_Data, 0);
    check("t4_mac_en", Mac_Enable, 0);
    step();
    check("t4_mac_en2", Mac_Enable, 0);
    check("t4_in_ready", In_Ready, 0);
    Res_Ready = 1'b1;
    step();
    In_Valid = 1'b0;
    check("t4_idle", Busy, 0);
    check("t4_mac_in1", Mac_In1, 0);

    // Reset after 2 of 4 beats
    start_vec(4);
    beat(32'h3F800000, 32'h3F800000);
    beat(32'h3F800000, 32'h3F800000);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check("t5_mac_en", Mac_Enable, 0);
    check("t5_busy", Busy, 0);
    check("t5_valid", Res_Valid, 0);
    start_vec(1);
    beat(32'h3F800000, 32'h3F800000);
    step(2);
    check("t5_follow_valid", Res_Valid, 1);
    check("t5_follow_data", Res_Data, 32'h3F800000);
    step();

    // Maximum length 15 of 1.0*1.0 = 15.0
    start_vec(4'hF);
    for (int i = 0; i < 15; i++) beat(32'h3F800000, 32'h3F800000);
    check("t6_drain_in_ready", In_Ready, 0);
    step(2);
    check("t6_valid", Res_Valid, 1);
    check("t6_data", Res_Data, 32'h41700000);
    step();
    check("t6_idle", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
